pb_interval_timer: RTL and testbench
====================================

// Module: pb_interval_timer
// PURPOSE
//  Programmable 16-bit down-count interval timer on the Picoblaze (kcpsm6) port I/O bus.
//  Sits directly beside the processor in the timers design.
//  Firmware programs prescale, reload and control registers, then waits on the interrupt.
//  The interrupt handler then updates the 7-segment display content.
// PARAMETERS
//  BASE_ADDR       8'h00  port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+6
//  PRESCALE_RESET  8'd99  reset value of PRESCALE; one tick every PRESCALE+1 clocks
// PORTS
//  clk            in   1  system clock (100 MHz)
//  reset_n        in   1  asynchronous, active-low reset
//  port_id        in   8  Picoblaze port address
//  out_port       in   8  Picoblaze write data
//  write_strobe   in   1  one-cycle write qualifier
//  read_strobe    in   1  one-cycle read qualifier
//  in_port        out  8  registered read data to Picoblaze
//  interrupt      out  1  level interrupt request
//  interrupt_ack  in   1  one-cycle acknowledge from Picoblaze
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0 CTRL       RW  [0] EN, [1] AUTO (auto-reload), [2] IE; [7:3] read 0
//   1 STATUS     R/W1C  [0] EXP (write 1 clears); [1] RUN = EN (read-only); [7:2] read 0
//   2 PRESCALE   RW  8-bit
//   3 RELOAD_LO  RW
//   4 RELOAD_HI  RW
//   5 COUNT_LO   R   returns count[7:0]; same cycle latches count[15:8] into a snapshot
//   6 COUNT_HI   R   returns the snapshot
//  Reset values:
//   - All registers 0, except PRESCALE = PRESCALE_RESET.
//   - count = 0, prescaler = 0, snapshot = 0, in_port = 0, interrupt = 0.
//  Read path:
//   - in_port <= mux(port_id) on every clk.
//   - Unmapped addresses return 8'h00.
//   - Data is valid one cycle after port_id is stable; read_strobe gates only snapshot capture.
//  Writes take effect on the clk edge where write_strobe=1 and port_id matches.
//  Start: write to CTRL that changes EN 0->1 loads count <= {RELOAD_HI,RELOAD_LO} and clears the prescaler.
//   - Writing EN=1 while already 1 does not restart the count.
//  Prescaler counts 0..PRESCALE while EN=1.
//   - tick = 1 for one cycle when prescaler == PRESCALE; prescaler then wraps to 0.
//   - PRESCALE=0 gives a tick every clock.
//  On tick with count != 0: count <= count-1.
//  On tick with count == 0 (expiry):
//   - EXP <= 1.
//   - If AUTO=1: count <= reload.
//   - If AUTO=0: EN <= 0 and count holds 0.
//   - Reload=0 with AUTO=1 therefore expires on every tick.
//  Period = (reload+1)*(PRESCALE+1) clocks.
//  EN=0: prescaler and count freeze; no ticks.
//  RELOAD writes while running affect only the next load.
//  interrupt = EXP & IE, registered; asserts the cycle after EXP sets.
//  interrupt_ack=1 or STATUS write with bit0=1 clears EXP.
//  Priority: same-cycle expiry and clear -> set wins (EXP stays 1).
//  Same-cycle CTRL write and expiry -> the CTRL write wins for EN; EXP still sets.
//  reset_n low at any time: immediate return to reset values; the running count is lost.
// TESTING
//  1 Reset: drive reset_n=0 mid-count -> in_port, interrupt, count = 0 at once; PRESCALE reads 99.
//  2 One-shot: PRESCALE=4, RELOAD=0x0003, CTRL=0x05 -> EXP sets exactly 20 clk after the CTRL write.
//    -> interrupt high 1 clk later; EN reads 0; no further expiry.
//  3 Auto-reload: PRESCALE=0, RELOAD=0x0009, CTRL=0x07 -> interrupt every 10 clk.
//    -> each pulse is cleared by a 1-cycle interrupt_ack.
//  4 Count read: RELOAD=0x1234, PRESCALE=255, running.
//    -> read COUNT_LO then COUNT_HI gives a coherent 16-bit value <= 0x1234; HI unchanged by ticks between the reads.
//  5 Collision: interrupt_ack on the expiry cycle -> EXP remains 1.
//    -> write STATUS=0x01 next cycle -> EXP=0, interrupt drops 1 clk later.
//  6 Bus decode: read port BASE_ADDR+7 -> 8'h00; write to BASE_ADDR+7 -> no register changes.

Source files
------------

// File: rtl/pb_interval_timer.sv
// Programmable 16-bit down-count interval timer for the kcpsm6 port bus.
// Seven byte registers from BASE_ADDR; a level interrupt fires when the count expires.
module pb_interval_timer #(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter logic [7:0] PRESCALE_RESET = 8'd99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_PRESCALE  = 3'd2;
    localparam logic [2:0] REG_RELOAD_LO = 3'd3;
    localparam logic [2:0] REG_RELOAD_HI = 3'd4;
    localparam logic [2:0] REG_COUNT_LO  = 3'd5;
    localparam logic [2:0] REG_COUNT_HI  = 3'd6;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        exp_q, exp_d;
    logic        irq_q, irq_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  snap_q, snap_d;
    logic [7:0]  in_port_q, in_port_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;

    // Offset arithmetic wraps mod 256, so a window straddling 8'hFF still decodes.
    logic [7:0] offset;
    logic       hit;
    logic [2:0] reg_sel;
    logic       wr_ctrl, wr_status, wr_prescale, wr_reload_lo, wr_reload_hi;
    logic       rd_count_lo, tick, expire;

    assign offset       = port_id - BASE_ADDR;
    assign hit          = offset < 8'd7;
    assign reg_sel      = offset[2:0];
    assign wr_ctrl      = write_strobe && hit && (reg_sel == REG_CTRL);
    assign wr_status    = write_strobe && hit && (reg_sel == REG_STATUS);
    assign wr_prescale  = write_strobe && hit && (reg_sel == REG_PRESCALE);
    assign wr_reload_lo = write_strobe && hit && (reg_sel == REG_RELOAD_LO);
    assign wr_reload_hi = write_strobe && hit && (reg_sel == REG_RELOAD_HI);
    assign rd_count_lo  = read_strobe && hit && (reg_sel == REG_COUNT_LO);
    assign tick         = en_q && (psc_q == prescale_q);
    assign expire       = tick && (count_q == 16'd0);

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a latch behind.
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        exp_d      = exp_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        psc_d      = psc_q;
        snap_d     = snap_q;
        irq_d      = exp_q && ie_q;

        if (en_q) psc_d = tick ? 8'd0 : psc_q + 8'd1;

        if (tick) begin
            if (count_q != 16'd0) count_d = count_q - 16'd1;
            else if (auto_q)      count_d = reload_q;
            else                  en_d    = 1'b0;
        end

        // Set beats clear when expiry and acknowledge land on the same edge.
        if (interrupt_ack || (wr_status && out_port[0])) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;

        // A CTRL write overrides the one-shot auto-disable; only a 0->1 edge restarts.
        if (wr_ctrl) begin
            en_d   = out_port[0];
            auto_d = out_port[1];
            ie_d   = out_port[2];
            if (out_port[0] && !en_q) begin
                count_d = reload_q;
                psc_d   = 8'd0;
            end
        end

        if (wr_prescale)  prescale_d     = out_port;
        if (wr_reload_lo) reload_d[7:0]  = out_port;
        if (wr_reload_hi) reload_d[15:8] = out_port;
        if (rd_count_lo)  snap_d         = count_q[15:8];
    end

    always_comb begin
        in_port_d = 8'h00;
        if (hit) begin
            case (reg_sel)
                REG_CTRL:      in_port_d = {5'b0, ie_q, auto_q, en_q};
                REG_STATUS:    in_port_d = {6'b0, en_q, exp_q};
                REG_PRESCALE:  in_port_d = prescale_q;
                REG_RELOAD_LO: in_port_d = reload_q[7:0];
                REG_RELOAD_HI: in_port_d = reload_q[15:8];
                REG_COUNT_LO:  in_port_d = count_q[7:0];
                REG_COUNT_HI:  in_port_d = snap_q;
                default:       in_port_d = 8'h00;
            endcase
        end
    end

    // NOTE: state is a handful of flops, not a memory, so every bit takes the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            exp_q      <= 1'b0;
            irq_q      <= 1'b0;
            prescale_q <= PRESCALE_RESET;
            psc_q      <= 8'd0;
            snap_q     <= 8'd0;
            in_port_q  <= 8'd0;
            reload_q   <= 16'd0;
            count_q    <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            exp_q      <= exp_d;
            irq_q      <= irq_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            snap_q     <= snap_d;
            in_port_q  <= in_port_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_pb_interval_timer.sv
// Self-checking bench for pb_interval_timer: directed scenarios with literal expectations
// plus randomized bus traffic, all compared every cycle against a behavioural model.
module tb_pb_interval_timer;

    localparam logic [7:0] BASE   = 8'h40;
    localparam int         PS_RST = 99;

    logic       clk;
    logic       reset_n;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    pb_interval_timer #(.BASE_ADDR(BASE), .PRESCALE_RESET(8'(PS_RST))) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model: registers as plain integers, one step per clock.
    logic m_en, m_auto, m_ie, m_exp, m_irq;
    int   m_prescale, m_div, m_reload, m_count;
    logic [7:0] m_snap, m_in_port;

    function automatic logic [7:0] m_read(input logic [7:0] off);
        case (off)
            8'd0:    return {5'b0, m_ie, m_auto, m_en};
            8'd1:    return {6'b0, m_en, m_exp};
            8'd2:    return 8'(m_prescale);
            8'd3:    return 8'(m_reload % 256);
            8'd4:    return 8'(m_reload / 256);
            8'd5:    return 8'(m_count % 256);
            8'd6:    return m_snap;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en <= 1'b0; m_auto <= 1'b0; m_ie <= 1'b0; m_exp <= 1'b0; m_irq <= 1'b0;
            m_prescale <= PS_RST; m_div <= 0; m_reload <= 0; m_count <= 0;
            m_snap <= 8'h00; m_in_port <= 8'h00;
        end else begin : step
            automatic logic [7:0] off = port_id - BASE;
            automatic logic wr = write_strobe && (off < 8'd7);
            automatic logic tk = m_en && (m_div == m_prescale);
            automatic int   n_div = m_en ? (tk ? 0 : m_div + 1) : m_div;
            automatic int   n_count = m_count;
            automatic logic n_en = m_en;
            automatic logic n_exp = m_exp;
            if (tk && m_count > 0) n_count = m_count - 1;
            if (tk && m_count == 0) begin
                if (m_auto) n_count = m_reload;
                else        n_en = 1'b0;
            end
            if (interrupt_ack || (wr && off == 8'd1 && out_port[0])) n_exp = 1'b0;
            if (tk && m_count == 0) n_exp = 1'b1;
            if (wr && off == 8'd0) begin
                n_en = out_port[0];
                m_auto <= out_port[1];
                m_ie <= out_port[2];
                if (out_port[0] && !m_en) begin
                    n_count = m_reload;
                    n_div = 0;
                end
            end
            if (wr && off == 8'd2) m_prescale <= int'(out_port);
            if (wr && off == 8'd3) m_reload <= (m_reload / 256) * 256 + int'(out_port);
            if (wr && off == 8'd4) m_reload <= int'(out_port) * 256 + m_reload % 256;
            if (read_strobe && off == 8'd5) m_snap <= 8'(m_count / 256);
            m_in_port <= m_read(off);
            m_irq <= m_exp && m_ie;
            m_en <= n_en; m_exp <= n_exp; m_div <= n_div; m_count <= n_count;
        end
    end

    always @(negedge clk) begin
        check("in_port_vs_model", 32'(in_port), 32'(m_in_port));
        check("interrupt_vs_model", 32'(interrupt), 32'(m_irq));
    end

    // Bus helpers: entered and left 1 ns after a rising edge.
    task automatic wr(input logic [7:0] off, input logic [7:0] data);
        port_id = BASE + off; out_port = data; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] data);
        port_id = BASE + off; read_strobe = 1'b1;
        @(posedge clk); #1;
        read_strobe = 1'b0;
        data = in_port;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_irq(input logic level, input int budget, input string name);
        int n = 0;
        while (interrupt !== level && n < budget) begin @(posedge clk); #1; n++; end
        check(name, 32'(interrupt), 32'(level));
    endtask

    logic [7:0]  d, lo, hi;
    logic [15:0] v;
    int          wc, t_prev;
    logic [7:0]  exp_tab [7] = '{8'h04, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};

    initial begin
        reset_n = 1'b0; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_interrupt", 32'(interrupt), 32'h0);
        reset_n = 1'b1;
        idle(1);
        rd(2, d); check("rst_prescale", 32'(d), 32'd99);
        rd(0, d); check("rst_ctrl", 32'(d), 32'h0);

        // One-shot: expiry 20 clocks after the CTRL write, interrupt one later.
        wr(2, 8'd4); wr(3, 8'h03); wr(4, 8'h00); wr(0, 8'h05);
        wc = cyc;
        port_id = BASE + 8'd1;
        wait_irq(1'b1, 100, "oneshot_irq");
        check("oneshot_latency", 32'(cyc - wc), 32'd21);
        rd(0, d); check("oneshot_en_off", 32'(d), 32'h04);
        rd(1, d); check("oneshot_status", 32'(d), 32'h01);
        wr(1, 8'h01);
        idle(2); check("oneshot_cleared", 32'(interrupt), 32'h0);
        idle(60); check("oneshot_no_more", 32'(interrupt), 32'h0);

        // Auto-reload every 10 clocks, each pulse acknowledged.
        wr(2, 8'd0); wr(3, 8'h09); wr(4, 8'h00); wr(0, 8'h07);
        wc = cyc; t_prev = wc;
        for (int k = 0; k < 3; k++) begin
            wait_irq(1'b1, 30, "auto_irq");
            check("auto_period", 32'(cyc - t_prev), (k == 0) ? 32'd11 : 32'd10);
            t_prev = cyc;
            interrupt_ack = 1'b1; idle(1); interrupt_ack = 1'b0;
            wait_irq(1'b0, 5, "auto_ack");
        end
        wr(0, 8'h00); wr(1, 8'h01);

        // Snapshot coherence across a high-byte borrow.
        wr(3, 8'h00); wr(4, 8'h01); wr(0, 8'h01);
        rd(5, lo); check("snap_lo", 32'(lo), 32'h00);
        idle(3);
        rd(6, hi); check("snap_hi_held", 32'(hi), 32'h01);
        rd(5, lo); check("snap_lo2", 32'(lo), 32'hFB);
        rd(6, hi); check("snap_hi2", 32'(hi), 32'h00);
        wr(0, 8'h00);
        wr(2, 8'd255); wr(3, 8'h34); wr(4, 8'h12); wr(0, 8'h01);
        idle(600);
        rd(5, lo); idle(300); rd(6, hi);
        v = {hi, lo};
        check("count_hi", 32'(hi), 32'h12);
        check("count_range", 32'(v <= 16'h1234 && v >= 16'h1230), 32'h1);
        wr(0, 8'h00);

        // Acknowledge on the expiry edge: set wins.
        wr(2, 8'd0); wr(3, 8'h04); wr(4, 8'h00); wr(0, 8'h05);
        idle(4);
        interrupt_ack = 1'b1; idle(1); interrupt_ack = 1'b0;
        idle(1); check("collide_irq", 32'(interrupt), 32'h1);
        rd(1, d); check("collide_exp", 32'(d), 32'h01);
        wr(1, 8'h01); check("collide_irq_lag", 32'(interrupt), 32'h1);
        idle(1); check("collide_irq_drop", 32'(interrupt), 32'h0);

        // Decode: unmapped ports read zero and ignore writes.
        rd(7, d); check("unmapped_rd", 32'(d), 32'h00);
        port_id = BASE - 8'd1; idle(2); check("below_base_rd", 32'(in_port), 32'h00);
        wr(7, 8'hFF);
        for (int i = 0; i < 7; i++) begin
            rd(8'(i), d); check($sformatf("regmap_%0d", i), 32'(d), 32'(exp_tab[i]));
        end

        // Reset in mid-count with the interrupt asserted.
        wr(3, 8'h02); wr(4, 8'h00); wr(0, 8'h07);
        wait_irq(1'b1, 20, "midrst_irq");
        port_id = BASE + 8'd1; idle(2);
        check("midrst_status", 32'(in_port), 32'h03);
        reset_n = 1'b0; #1;
        check("midrst_in_port", 32'(in_port), 32'h0);
        check("midrst_interrupt", 32'(interrupt), 32'h0);
        idle(2); reset_n = 1'b1;
        rd(2, d); check("midrst_prescale", 32'(d), 32'd99);
        rd(5, d); check("midrst_count_lo", 32'(d), 32'h0);
        rd(6, d); check("midrst_count_hi", 32'(d), 32'h0);
        rd(0, d); check("midrst_ctrl", 32'(d), 32'h0);

        // Randomized traffic, checked only by the per-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            automatic int r = $urandom_range(0, 99);
            automatic int s = $urandom_range(0, 99);
            automatic logic [7:0] off = 8'($urandom_range(0, 8));
            port_id = (r < 90) ? BASE + off : 8'($urandom);
            write_strobe = s < 25;
            read_strobe  = (s >= 25) && (s < 50);
            case (off)
                8'd2:    out_port = 8'($urandom_range(0, 3));
                8'd3:    out_port = 8'($urandom_range(0, 12));
                8'd4:    out_port = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
                default: out_port = 8'($urandom);
            endcase
            interrupt_ack = $urandom_range(0, 19) == 0;
            if (i == 2000) reset_n = 1'b0;
            if (i == 2002) reset_n = 1'b1;
            idle(1);
        end
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
